// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_RMW_WR = 1'b1
  } state_t;

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a loaded memory word.
// Latency: purely combinational.
// Backpressure: none.
// Ports: word (memory word), addr (byte offset in word), funct3 (size/sign),
//        result (extended 32-bit load value; 0 for unsupported funct3).
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr, 3'b000} +: 8];
  assign half_sel = word[{addr[1], 4'b0000} +: 16];

  always_comb begin
    result = 32'h0;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      F3_W:    result = word;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller: byte/half/word core accesses onto a word-only memory.
// Latency: loads and word stores in the request cycle; sub-word stores take 2 cycles.
// Backpressure: stall is high during the read half of a read-modify-write.
// Ports: clk, rst (async active-high); core side req_read, req_write, funct3,
//        addr, wdata -> rdata, stall, misaligned, err; memory side mem_read,
//        mem_write, mem_addr, mem_wdata <- mem_rdata (combinational read).
module data_mem_ctrl
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state, next_state;
  logic [31:0] lat_word;
  logic [8:0]  lat_addr;
  logic [15:0] lat_wdata;
  logic [2:0]  lat_f3;
  logic        latch_en;

  logic        is_load, is_store;
  logic        load_f3_ok, store_f3_ok, align_bad, illegal;
  logic [31:0] load_val;
  logic [31:0] merged;

  // A load wins when both requests are raised together
  assign is_load  = req_read;
  assign is_store = req_write & ~req_read;

  assign load_f3_ok  = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
  assign store_f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
  assign align_bad   = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                       ((funct3 == F3_W) && (addr[1:0] != 2'b00));
  assign illegal     = is_load ? (!load_f3_ok || align_bad) : (!store_f3_ok || align_bad);

  load_extend u_load_extend (
    .word   (mem_rdata),
    .addr   (addr[1:0]),
    .funct3 (funct3),
    .result (load_val)
  );

  // Drop the latched store data into its lane of the latched memory word
  always_comb begin
    merged = lat_word;
    if (lat_f3 == F3_B)
      merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    else
      merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 9'h0;
    mem_wdata  = 32'h0;
    rdata      = 32'h0;
    misaligned = 1'b0;
    latch_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_load || is_store) begin
          if (illegal) begin
            misaligned = 1'b1;
          end else if (is_load) begin
            mem_read = 1'b1;
            mem_addr = {addr[8:2], 2'b00};
            rdata    = load_val;
          end else if (funct3 == F3_W) begin
            mem_write = 1'b1;
            mem_addr  = {addr[8:2], 2'b00};
            mem_wdata = wdata;
          end else begin
            // Sub-word store: read the containing word now, write it back next cycle
            mem_read   = 1'b1;
            mem_addr   = {addr[8:2], 2'b00};
            stall      = 1'b1;
            latch_en   = 1'b1;
            next_state = S_RMW_WR;
          end
        end
      end
      S_RMW_WR: begin
        // Core inputs are ignored here; everything comes from the latches
        mem_write  = 1'b1;
        mem_addr   = {lat_addr[8:2], 2'b00};
        mem_wdata  = merged;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      err       <= 1'b0;
      lat_word  <= 32'h0;
      lat_addr  <= 9'h0;
      lat_wdata <= 16'h0;
      lat_f3    <= 3'h0;
    end else begin
      state <= next_state;
      err   <= err | misaligned;
      if (latch_en) begin
        lat_word  <= mem_rdata;
        lat_addr  <= addr;
        lat_wdata <= wdata[15:0];
        lat_f3    <= funct3;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [2:0]  funct3;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall, misaligned, err;
  logic        mem_read, mem_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [128];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_read   (req_read),
    .req_write  (req_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misaligned (misaligned),
    .err        (err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Word-addressed memory model: combinational read, write on rising edge
  assign mem_rdata = mem[mem_addr[8:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[8:2]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rr, input logic rw, input logic [2:0] f3,
                       input logic [8:0] a, input logic [31:0] wd);
    req_read  = rr;
    req_write = rw;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
  endtask

  typedef struct {
    string       name;
    logic        rr;
    logic        rw;
    logic [2:0]  f3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] e_rdata;
    logic        e_stall;
    logic        e_mis;
    logic        e_mrd;
    logic        e_mwr;
    logic [8:0]  e_maddr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[8] = 32'hAABBCCDD;   // byte address 0x020
    mem[4] = 32'h11223344;   // byte address 0x010

    vecs[0] = '{"lb_023",  1, 0, F3_B,  9'h023, 32'h0, 32'hFFFFFFAA, 0, 0, 1, 0, 9'h020};
    vecs[1] = '{"lbu_023", 1, 0, F3_BU, 9'h023, 32'h0, 32'h000000AA, 0, 0, 1, 0, 9'h020};
    vecs[2] = '{"lh_022",  1, 0, F3_H,  9'h022, 32'h0, 32'hFFFFAABB, 0, 0, 1, 0, 9'h020};
    vecs[3] = '{"lhu_020", 1, 0, F3_HU, 9'h020, 32'h0, 32'h0000CCDD, 0, 0, 1, 0, 9'h020};
    vecs[4] = '{"lw_020",  1, 0, F3_W,  9'h020, 32'h0, 32'hAABBCCDD, 0, 0, 1, 0, 9'h020};
    vecs[5] = '{"lb_021",  1, 0, F3_B,  9'h021, 32'h0, 32'hFFFFFFCC, 0, 0, 1, 0, 9'h020};
    vecs[6] = '{"lbu_021", 1, 0, F3_BU, 9'h021, 32'h0, 32'h000000CC, 0, 0, 1, 0, 9'h020};
    vecs[7] = '{"sw_014",  0, 1, F3_W,  9'h014, 32'hDEADBEEF, 32'h0, 0, 0, 0, 1, 9'h014};
    vecs[8] = '{"both_req",1, 1, F3_W,  9'h010, 32'h55555555, 32'h11223344, 0, 0, 1, 0, 9'h010};
    vecs[9] = '{"idle",    0, 0, F3_W,  9'h010, 32'h0, 32'h0, 0, 0, 0, 0, 9'h000};

    drive(0, 0, F3_B, 9'h0, 32'h0);
    rst = 1'b1;
    #12;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_err",   {31'h0, err}, 32'h0);
    chk("rst_mrd",   {31'h0, mem_read}, 32'h0);
    chk("rst_mwr",   {31'h0, mem_write}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle accesses from the table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].rr, vecs[i].rw, vecs[i].f3, vecs[i].a, vecs[i].wd);
      #1;
      chk({vecs[i].name, "_rdata"}, rdata, vecs[i].e_rdata);
      chk({vecs[i].name, "_stall"}, {31'h0, stall}, {31'h0, vecs[i].e_stall});
      chk({vecs[i].name, "_mis"},   {31'h0, misaligned}, {31'h0, vecs[i].e_mis});
      chk({vecs[i].name, "_mrd"},   {31'h0, mem_read}, {31'h0, vecs[i].e_mrd});
      chk({vecs[i].name, "_mwr"},   {31'h0, mem_write}, {31'h0, vecs[i].e_mwr});
      chk({vecs[i].name, "_maddr"}, {23'h0, mem_addr}, {23'h0, vecs[i].e_maddr});
      if (vecs[i].e_mwr)
        chk({vecs[i].name, "_wdata"}, mem_wdata, vecs[i].wd);
    end
    @(negedge clk);
    drive(0, 0, F3_B, 9'h0, 32'h0);
    chk("sw_mem_014", mem[5], 32'hDEADBEEF);
    chk("both_mem_010", mem[4], 32'h11223344);
    chk("legal_err", {31'h0, err}, 32'h0);

    // Byte store: read/stall cycle, then merged write, then load back
    drive(0, 1, F3_B, 9'h011, 32'h000000EE);
    #1;
    chk("sb_c1_mrd",   {31'h0, mem_read}, 32'h1);
    chk("sb_c1_mwr",   {31'h0, mem_write}, 32'h0);
    chk("sb_c1_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    chk("sb_c2_mwr",   {31'h0, mem_write}, 32'h1);
    chk("sb_c2_mrd",   {31'h0, mem_read}, 32'h0);
    chk("sb_c2_stall", {31'h0, stall}, 32'h0);
    chk("sb_c2_maddr", {23'h0, mem_addr}, 32'h010);
    chk("sb_c2_wdata", mem_wdata, 32'h1122EE44);
    @(negedge clk);
    drive(1, 0, F3_W, 9'h010, 32'h0);
    #1;
    chk("sb_lw_010", rdata, 32'h1122EE44);

    // Half store onto the merged word
    @(negedge clk);
    drive(0, 1, F3_H, 9'h012, 32'h0000BEEF);
    #1;
    chk("sh_c1_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    chk("sh_c2_wdata", mem_wdata, 32'hBEEFEE44);
    @(negedge clk);
    drive(0, 0, F3_B, 9'h0, 32'h0);
    chk("sh_mem_010", mem[4], 32'hBEEFEE44);

    // Misaligned half store
    @(negedge clk);
    drive(0, 1, F3_H, 9'h013, 32'h0000FFFF);
    #1;
    chk("sh013_mis", {31'h0, misaligned}, 32'h1);
    chk("sh013_mrd", {31'h0, mem_read}, 32'h0);
    chk("sh013_mwr", {31'h0, mem_write}, 32'h0);
    chk("sh013_err_now", {31'h0, err}, 32'h0);
    @(negedge clk);
    drive(0, 0, F3_B, 9'h0, 32'h0);
    #1;
    chk("sh013_err_next", {31'h0, err}, 32'h1);
    chk("sh013_mem", mem[4], 32'hBEEFEE44);

    // Misaligned word load
    @(negedge clk);
    drive(1, 0, F3_W, 9'h016, 32'h0);
    #1;
    chk("lw016_mis", {31'h0, misaligned}, 32'h1);
    chk("lw016_rdata", rdata, 32'h0);
    chk("lw016_mrd", {31'h0, mem_read}, 32'h0);
    chk("lw016_mwr", {31'h0, mem_write}, 32'h0);

    // Illegal store funct3 (BU)
    @(negedge clk);
    drive(0, 1, F3_BU, 9'h010, 32'h000000AB);
    #1;
    chk("sbu_mis", {31'h0, misaligned}, 32'h1);
    chk("sbu_mwr", {31'h0, mem_write}, 32'h0);
    @(negedge clk);
    drive(0, 0, F3_B, 9'h0, 32'h0);
    #1;
    chk("err_sticky", {31'h0, err}, 32'h1);
    chk("sbu_mem", mem[4], 32'hBEEFEE44);

    // Reset in the read cycle of a byte store
    @(negedge clk);
    drive(0, 1, F3_B, 9'h010, 32'h000000FF);
    #1;
    chk("rmw_rst_c1_stall", {31'h0, stall}, 32'h1);
    #1;
    rst = 1'b1;
    drive(0, 0, F3_B, 9'h0, 32'h0);
    #1;
    chk("rmw_rst_stall", {31'h0, stall}, 32'h0);
    chk("rmw_rst_mwr", {31'h0, mem_write}, 32'h0);
    @(negedge clk);
    chk("rmw_rst_mwr2", {31'h0, mem_write}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rmw_rst_mwr3", {31'h0, mem_write}, 32'h0);
    chk("rmw_rst_err", {31'h0, err}, 32'h0);
    chk("rmw_rst_mem", mem[4], 32'hBEEFEE44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
